uart_rxd: RTL and testbench

//   UART receiver (8N1, LSB first). Mirror of the TxD transmitter on the same serial link.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rxd.sv | 193 +++++++++++++++++++
 tb/tb_uart_rxd.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-period helper, frame width.
// Used by both the RxD receiver and the TxD transmitter.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops reset to 1
// so an idle-high line never shows a false edge on reset release.
module uart_sync2
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_p0 <= 1'b1;
            q       <= 1'b1;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/uart_rxd.sv
// UART receiver, 8N1 LSB first, mid-bit sampling with one-cycle valid/error strobes.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_rxd
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       iCLOCK,
    input  logic       iNRESET,
    input  logic       iRX,
    output logic [7:0] oRXDATA,
    output logic       oRXVALID,
    output logic       oRXBUSY,
    output logic       oRXERR
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rst;
    logic                 rx_s;
    logic                 rx_d;
    logic                 fall;
    rx_state_t            state;
    rx_state_t            state_nxt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shift;
    logic                 cnt_clr;
    logic                 data_smp;
    logic                 stop_smp;
    logic                 busy_nxt;
    logic                 par_bad;

    // Reset asserts immediately but releases two clocks later, in step with iCLOCK.
    uart_sync2 u_rst_sync (
        .clk (iCLOCK),
        .rst (iNRESET),
        .d   (1'b0),
        .q   (rst)
    );

    uart_sync2 u_rx_sync (
        .clk (iCLOCK),
        .rst (rst),
        .d   (iRX),
        .q   (rx_s)
    );

    assign fall = rx_d & ~rx_s;

    always_ff @(posedge iCLOCK or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rx_d    <= 1'b1;
            bit_cnt <= '0;
            idx     <= '0;
        end else begin
            state <= state_nxt;
            rx_d  <= rx_s;
            if (cnt_clr || state == IDLE) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (state == START) begin
                idx <= '0;
            end else if (data_smp) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_smp;
`endif

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        data_smp  = 1'b0;
        stop_smp  = 1'b0;
        busy_nxt  = oRXBUSY;
`ifdef UART_RX_PARITY_EN
        par_smp   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                    cnt_clr   = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            START: begin
                if (bit_cnt == CNT_HALF) begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt = DATA;
                        cnt_clr   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (bit_cnt == CNT_FULL) begin
                    data_smp = 1'b1;
                    cnt_clr  = 1'b1;
                    if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_cnt == CNT_FULL) begin
                    par_smp   = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_cnt == CNT_FULL) begin
                    stop_smp  = 1'b1;
                    cnt_clr   = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Data-path shift register: no reset, only ever read after a full frame.
    always_ff @(posedge iCLOCK) begin
        if (data_smp) begin
            shift[idx] <= rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge iCLOCK or posedge rst) begin
        if (rst) begin
            par_bad <= 1'b0;
        end else if (par_smp) begin
            par_bad <= ((^shift) ^ rx_s) != PARITY_ODD;
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge iCLOCK or posedge rst) begin
        if (rst) begin
            oRXDATA  <= 8'h00;
            oRXVALID <= 1'b0;
            oRXERR   <= 1'b0;
            oRXBUSY  <= 1'b0;
        end else begin
            oRXVALID <= 1'b0;
            oRXERR   <= 1'b0;
            oRXBUSY  <= busy_nxt;
            if (stop_smp) begin
                if (rx_s && !par_bad) begin
                    oRXDATA  <= shift;
                    oRXVALID <= 1'b1;
                end else begin
                    oRXERR <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rxd.sv
// Self-checking bench for uart_rxd: directed frames plus randomized frames checked
// against a frame-level event model (expected valid/error strobes and held data).
module tb_uart_rxd;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115_200;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int CLK_NS   = 20;
    localparam int BIT_NS   = CPB * CLK_NS;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int EXP_BUSY = CPB / 2 + (8 + PB) * CPB + CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rxdata;
    logic       rxvalid;
    logic       rxbusy;
    logic       rxerr;

    uart_rxd #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD)
    ) dut (
        .iCLOCK   (clk),
        .iNRESET  (rst),
        .iRX      (rx),
        .oRXDATA  (rxdata),
        .oRXVALID (rxvalid),
        .oRXBUSY  (rxbusy),
        .oRXERR   (rxerr)
    );

    always #(CLK_NS / 2) clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        obs_q[$];
    logic [7:0] model_data = 8'h00;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         busy_run = 0;
    int         busy_len = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if (rst) begin
            busy_run = 0;
        end else begin
            if (rxvalid || rxerr) begin
                e.is_err = rxerr;
                e.data   = rxdata;
                obs_q.push_back(e);
                if (rxvalid && rxerr) chk("valid_err_excl", 32'(rxvalid & rxerr), 32'd0);
            end
            if (rxbusy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                busy_len = busy_run;
                busy_run = 0;
            end
        end
    end

    // Frame-level reference: a frame is good iff its stop bit is 1 and (when used) parity matches.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        ev_t  e;
        logic good;
        rx = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #BIT_NS;
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        #BIT_NS;
`endif
        rx = stop;
        #BIT_NS;
        good     = stop && !(PB != 0 && par_flip);
        e.is_err = !good;
        e.data   = good ? d : model_data;
        if (good) model_data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_events(input string tag);
        ev_t o;
        ev_t x;
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            x = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_kind"}, 32'(o.is_err), 32'(x.is_err));
            chk({tag, "_data"}, 32'(o.data), 32'(x.data));
        end
        exp_q.delete();
        obs_q.delete();
        chk({tag, "_rxdata"}, 32'(rxdata), 32'(model_data));
    endtask

    initial begin
        logic [7:0] d;
        logic       stop;
        logic       flip;
        int         gap;

        rx  = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_data",  32'(rxdata),  32'h00);
        chk("rst_valid", 32'(rxvalid), 32'd0);
        chk("rst_busy",  32'(rxbusy),  32'd0);
        chk("rst_err",   32'(rxerr),   32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        send_frame(8'hA5, 1'b1, 1'b0);
        #BIT_NS;
        @(negedge clk);
        check_events("a5");
        chk("a5_busy_len_ok", 32'(busy_len >= EXP_BUSY - 4 && busy_len <= EXP_BUSY + 4), 32'd1);

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        #BIT_NS;
        @(negedge clk);
        check_events("b2b");

        rx = 1'b0;
        #2000;
        rx = 1'b1;
        #(2 * BIT_NS);
        @(negedge clk);
        check_events("glitch");
        chk("glitch_busy", 32'(rxbusy), 32'd0);

        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        #(19 * BIT_NS);
        @(negedge clk);
        check_events("break");
        rx = 1'b1;
        #(2 * BIT_NS);
        @(negedge clk);
        check_events("break_release");
        chk("break_busy", 32'(rxbusy), 32'd0);

        d  = 8'hE6;
        rx = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            #BIT_NS;
        end
        rx = d[4];
        #(BIT_NS / 2);
        rst = 1'b1;
        #1;
        chk("midrst_data",  32'(rxdata),  32'h00);
        chk("midrst_valid", 32'(rxvalid), 32'd0);
        chk("midrst_busy",  32'(rxbusy),  32'd0);
        chk("midrst_err",   32'(rxerr),   32'd0);
        model_data = 8'h00;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #(2 * BIT_NS);
        @(negedge clk);
        obs_q.delete();
        send_frame(8'h81, 1'b1, 1'b0);
        #BIT_NS;
        @(negedge clk);
        check_events("after_rst");

        for (int n = 0; n < 5; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            flip = (PB != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            send_frame(d, stop, flip);
            gap = $urandom_range(0, 6);
            if (!stop && gap < 4) gap = 4;
            rx = 1'b1;
            #(gap * (BIT_NS / 4));
        end
        rx = 1'b1;
        #(2 * BIT_NS);
        @(negedge clk);
        check_events("rand");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        #BIT_NS;
        @(negedge clk);
        check_events("parity");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
